// File: rtl/mips_pkg.sv
// mips_pkg: instruction kind codes, MIPS opcode/func constants and loader states
// shared by the instruction packer, the loader and the P4 control decoder.
package mips_pkg;
  localparam logic [3:0] KIND_NOP  = 4'd0;
  localparam logic [3:0] KIND_ADDU = 4'd1;
  localparam logic [3:0] KIND_SUBU = 4'd2;
  localparam logic [3:0] KIND_JR   = 4'd3;
  localparam logic [3:0] KIND_ORI  = 4'd4;
  localparam logic [3:0] KIND_LW   = 4'd5;
  localparam logic [3:0] KIND_SW   = 4'd6;
  localparam logic [3:0] KIND_BEQ  = 4'd7;
  localparam logic [3:0] KIND_LUI  = 4'd8;
  localparam logic [3:0] KIND_JAL  = 4'd9;
  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_SW      = 6'b101011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] FUNC_ADDU = 6'b100001;
  localparam logic [5:0] FUNC_SUBU = 6'b100011;
  localparam logic [5:0] FUNC_JR   = 6'b001000;
  // beq $0,$0,-1: parks the core on a self-loop once the program ends
  localparam logic [31:0] TERM_WORD = 32'h1000_FFFF;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_TERM, S_DONE} state_t;
endpackage

// File: rtl/mips_inst_pack.sv
// mips_inst_pack: packs a symbolic instruction into a 32-bit MIPS word and
// flags kinds outside the supported subset.
module mips_inst_pack
  import mips_pkg::*;
(
  input  logic [3:0]  i_kind,
  input  logic [4:0]  i_rs,
  input  logic [4:0]  i_rt,
  input  logic [4:0]  i_rd,
  input  logic [15:0] i_imm,
  input  logic [25:0] i_tgt,
  output logic [31:0] o_word,
  output logic        o_illegal
);
  always_comb begin
    o_word = '0;
    o_illegal = 1'b0;
    case (i_kind)
      KIND_NOP:  o_word = '0;
      KIND_ADDU: o_word = {OP_SPECIAL, i_rs, i_rt, i_rd, 5'd0, FUNC_ADDU};
      KIND_SUBU: o_word = {OP_SPECIAL, i_rs, i_rt, i_rd, 5'd0, FUNC_SUBU};
      KIND_JR:   o_word = {OP_SPECIAL, i_rs, 15'd0, FUNC_JR};
      KIND_ORI:  o_word = {OP_ORI, i_rs, i_rt, i_imm};
      KIND_LW:   o_word = {OP_LW, i_rs, i_rt, i_imm};
      KIND_SW:   o_word = {OP_SW, i_rs, i_rt, i_imm};
      KIND_BEQ:  o_word = {OP_BEQ, i_rs, i_rt, i_imm};
      KIND_LUI:  o_word = {OP_LUI, 5'd0, i_rt, i_imm};
      KIND_JAL:  o_word = {OP_JAL, i_tgt};
      default:   o_illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/mips_inst_loader.sv
// mips_inst_loader: accepts symbolic instructions over valid/ready, writes the
// packed words sequentially into IM and closes each session with a self-loop.
module mips_inst_loader
  import mips_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_tgt,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              err
);
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);
  state_t r_state, w_state_n;
  logic r_ready, r_we, r_done, r_err, r_fp;
  logic w_ready_n, w_we_n, w_done_n, w_err_n, w_fp_n;
  logic [ADDR_W-1:0] r_addr, r_ptr, w_addr_n, w_ptr_n;
  logic [31:0] r_wdata, w_wdata_n, w_word;
  logic [ADDR_W:0] r_count, w_count_n;
  logic w_illegal, w_acc;
  mips_inst_pack u_pack (
    .i_kind    (in_kind),
    .i_rs      (in_rs),
    .i_rt      (in_rt),
    .i_rd      (in_rd),
    .i_imm     (in_imm),
    .i_tgt     (in_tgt),
    .o_word    (w_word),
    .o_illegal (w_illegal)
  );
  assign w_acc = in_valid && r_ready;
  always_comb begin
    w_state_n = r_state;
    w_we_n = 1'b0;
    w_addr_n = r_addr;
    w_wdata_n = r_wdata;
    w_count_n = r_count;
    w_ptr_n = r_ptr;
    w_done_n = r_done;
    w_err_n = 1'b0;
    w_fp_n = r_fp;
    case (r_state)
      S_IDLE, S_DONE: if (start) begin
        w_state_n = S_LOAD;
        w_count_n = '0;
        w_ptr_n = '0;
        w_done_n = 1'b0;
        w_fp_n = 1'b0;
      end
      S_LOAD: begin
        if (w_acc && !w_illegal) begin
          w_we_n = 1'b1;
          w_addr_n = r_ptr;
          w_wdata_n = w_word;
          w_ptr_n = r_ptr + ADDR_W'(1);
          w_count_n = r_count + (ADDR_W+1)'(1);
        end
        w_err_n = w_acc && w_illegal;
        // a flush that coincides with a transfer is deferred one cycle
        if (flush && w_acc) w_fp_n = 1'b1;
        else if (flush || (r_fp && !w_acc)) begin
          w_state_n = S_TERM;
          w_we_n = 1'b1;
          w_addr_n = r_ptr;
          w_wdata_n = TERM_WORD;
          w_count_n = r_count + (ADDR_W+1)'(1);
          w_fp_n = 1'b0;
        end
      end
      S_TERM: begin
        w_state_n = S_DONE;
        w_done_n = 1'b1;
      end
    endcase
    w_ready_n = (w_state_n == S_LOAD) && !w_fp_n && (w_count_n < LAST);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_ready <= 1'b0;
      r_we <= 1'b0;
      r_addr <= '0;
      r_wdata <= '0;
      r_count <= '0;
      r_ptr <= '0;
      r_done <= 1'b0;
      r_err <= 1'b0;
      r_fp <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_ready <= w_ready_n;
      r_we <= w_we_n;
      r_addr <= w_addr_n;
      r_wdata <= w_wdata_n;
      r_count <= w_count_n;
      r_ptr <= w_ptr_n;
      r_done <= w_done_n;
      r_err <= w_err_n;
      r_fp <= w_fp_n;
    end
  end
  assign in_ready = r_ready;
  assign im_we = r_we;
  assign im_addr = r_addr;
  assign im_wdata = r_wdata;
  assign count = r_count;
  assign done = r_done;
  assign err = r_err;
endmodule

// File: tb/tb_mips_inst_loader.sv
// tb_mips_inst_loader: directed and randomized checks of the instruction loader
// against an encoding model and an IM image captured from the write port.
module tb_mips_inst_loader;
  localparam int DEPTH = 16, AW = 4, SD = 4, SAW = 2;
  localparam logic [31:0] TERM = 32'h1000FFFF;
  logic clk = 0, reset = 0, start = 0, flush = 0, in_valid = 0;
  logic [3:0] in_kind = 0;
  logic [4:0] in_rs = 0, in_rt = 0, in_rd = 0;
  logic [15:0] in_imm = 0;
  logic [25:0] in_tgt = 0;
  logic in_ready, im_we, done, err;
  logic [AW-1:0] im_addr;
  logic [31:0] im_wdata;
  logic [AW:0] count;
  logic s_ready, s_we, s_done, s_err;
  logic [SAW-1:0] s_addr;
  logic [31:0] s_wdata;
  logic [SAW:0] s_count;
  int n_chk = 0, n_fail = 0, errs = 0;
  typedef struct {int addr; logic [31:0] data;} wr_t;
  wr_t wq[$];

  always #5 clk = ~clk;

  mips_inst_loader #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm), .in_tgt(in_tgt),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata), .count(count), .done(done), .err(err));

  mips_inst_loader #(.DEPTH(SD), .ADDR_W(SAW)) dut_small (
    .clk(clk), .reset(reset), .start(start), .flush(flush), .in_valid(in_valid), .in_ready(s_ready),
    .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm), .in_tgt(in_tgt),
    .im_we(s_we), .im_addr(s_addr), .im_wdata(s_wdata), .count(s_count), .done(s_done), .err(s_err));

  always @(negedge clk) begin
    if (im_we) wq.push_back('{int'(im_addr), im_wdata});
    if (err) errs++;
  end

  function automatic logic [31:0] enc(int k, longint rs, longint rt, longint rd, longint imm, longint tgt);
    case (k)
      1: return 32'(rs * 2097152 + rt * 65536 + rd * 2048 + 33);
      2: return 32'(rs * 2097152 + rt * 65536 + rd * 2048 + 35);
      3: return 32'(rs * 2097152 + 8);
      4: return 32'(13 * 67108864 + rs * 2097152 + rt * 65536 + imm);
      5: return 32'(35 * 67108864 + rs * 2097152 + rt * 65536 + imm);
      6: return 32'(43 * 67108864 + rs * 2097152 + rt * 65536 + imm);
      7: return 32'(4 * 67108864 + rs * 2097152 + rt * 65536 + imm);
      8: return 32'(15 * 67108864 + rt * 65536 + imm);
      9: return 32'(3 * 67108864 + tgt);
      default: return 32'd0;
    endcase
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k, input int rs, input int rt, input int rd, input int imm, input int tgt);
    in_kind = 4'(k); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd);
    in_imm = 16'(imm); in_tgt = 26'(tgt); in_valid = 1;
  endtask

  task automatic do_start;
    in_valid = 0; start = 1;
    step;
    start = 0;
    wq.delete();
    errs = 0;
  endtask

  task automatic end_session;
    in_valid = 0; flush = 1;
    step;
    flush = 0;
    step;
  endtask

  task automatic test_reset;
    reset = 0;
    step; step;
    n_chk++; if ({in_ready, im_we, im_addr, im_wdata, count, done, err} !== '0) begin
      n_fail++; $display("FAIL reset_big got=%h exp=0", {in_ready, im_we, im_addr, im_wdata, count, done, err}); end
    n_chk++; if ({s_ready, s_we, s_addr, s_wdata, s_count, s_done, s_err} !== '0) begin
      n_fail++; $display("FAIL reset_small got=%h exp=0", {s_ready, s_we, s_addr, s_wdata, s_count, s_done, s_err}); end
    reset = 1;
    step;
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL idle_ready got=%b exp=0", in_ready); end
  endtask

  task automatic test_basic;
    do_start;
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL start_ready got=%b exp=1", in_ready); end
    drive(1, 1, 2, 3, 0, 0);
    step;
    in_valid = 0;
    n_chk++; if ({im_we, im_addr, im_wdata, count} !== {1'b1, 4'd0, 32'h00221821, 5'd1}) begin
      n_fail++; $display("FAIL basic_addu got=%h exp=%h", {im_we, im_addr, im_wdata, count}, {1'b1, 4'd0, 32'h00221821, 5'd1}); end
    end_session;
    n_chk++; if ({done, count} !== {1'b1, 5'd2}) begin n_fail++; $display("FAIL basic_done got=%h exp=%h", {done, count}, {1'b1, 5'd2}); end
  endtask

  task automatic test_back_to_back;
    int k[4], rs[4], rt[4], imm[4], tgt[4];
    logic [31:0] exp[4];
    k = '{4, 8, 6, 9}; rs = '{0, 7, 29, 0}; rt = '{8, 1, 2, 0};
    imm = '{'h1234, 'hABCD, 'hFFFC, 0}; tgt = '{0, 0, 0, 'h0C00};
    exp = '{32'h34081234, 32'h3C01ABCD, 32'hAFA2FFFC, 32'h0C000C00};
    do_start;
    for (int i = 0; i < 4; i++) begin
      drive(k[i], rs[i], rt[i], 0, imm[i], tgt[i]);
      step;
      n_chk++; if ({im_we, im_addr, im_wdata, in_ready} !== {1'b1, AW'(i), exp[i], 1'b1}) begin
        n_fail++; $display("FAIL b2b_%0d got=%h exp=%h", i, {im_we, im_addr, im_wdata, in_ready}, {1'b1, AW'(i), exp[i], 1'b1}); end
    end
    in_valid = 0;
    step;
    n_chk++; if ({im_we, im_addr, im_wdata} !== {1'b0, 4'd3, exp[3]}) begin
      n_fail++; $display("FAIL b2b_hold got=%h exp=%h", {im_we, im_addr, im_wdata}, {1'b0, 4'd3, exp[3]}); end
    flush = 1;
    step;
    flush = 0;
    n_chk++; if ({im_we, im_addr, im_wdata, count, done} !== {1'b1, 4'd4, TERM, 5'd5, 1'b0}) begin
      n_fail++; $display("FAIL b2b_term got=%h exp=%h", {im_we, im_addr, im_wdata, count, done}, {1'b1, 4'd4, TERM, 5'd5, 1'b0}); end
    step;
    n_chk++; if ({im_we, done, in_ready} !== 3'b010) begin n_fail++; $display("FAIL b2b_done got=%b exp=010", {im_we, done, in_ready}); end
    flush = 1;
    step;
    flush = 0;
    n_chk++; if ({im_we, done, count} !== {1'b0, 1'b1, 5'd5}) begin
      n_fail++; $display("FAIL flush_in_done got=%h exp=%h", {im_we, done, count}, {1'b0, 1'b1, 5'd5}); end
  endtask

  task automatic test_illegal;
    do_start;
    drive(1, 4, 5, 6, 0, 0);
    step;
    drive(15, 1, 1, 1, 1, 1);
    start = 1;
    step;
    start = 0;
    n_chk++; if ({im_we, err, count, in_ready, s_err} !== {1'b0, 1'b1, 5'd1, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL illegal_pulse got=%h exp=%h", {im_we, err, count, in_ready, s_err}, {1'b0, 1'b1, 5'd1, 1'b1, 1'b1}); end
    drive(4, 3, 9, 0, 'h00FF, 0);
    step;
    in_valid = 0;
    n_chk++; if ({im_we, im_addr, im_wdata, err, count} !== {1'b1, 4'd1, enc(4, 3, 9, 0, 'h00FF, 0), 1'b0, 5'd2}) begin
      n_fail++; $display("FAIL illegal_next got=%h exp=%h", {im_we, im_addr, im_wdata, err, count}, {1'b1, 4'd1, enc(4, 3, 9, 0, 'h00FF, 0), 1'b0, 5'd2}); end
    step;
    n_chk++; if (errs !== 1) begin n_fail++; $display("FAIL illegal_count got=%0d exp=1", errs); end
    n_chk++; if (wq.size() !== 2 || wq[0].data !== enc(1, 4, 5, 6, 0, 0)) begin
      n_fail++; $display("FAIL illegal_writes got=%0d exp=2", wq.size()); end
    end_session;
  endtask

  task automatic test_full;
    int acc = 0;
    logic exp_acc;
    do_start;
    for (int i = 0; i < 6; i++) begin
      exp_acc = (acc < SD - 1);
      drive(7, i, i + 1, 0, i, 0);
      n_chk++; if (s_ready !== exp_acc) begin n_fail++; $display("FAIL full_ready_%0d got=%b exp=%b", i, s_ready, exp_acc); end
      step;
      if (exp_acc) begin
        acc++;
        n_chk++; if ({s_we, s_addr, s_wdata, s_count} !== {1'b1, 2'(acc - 1), enc(7, i, i + 1, 0, i, 0), 3'(acc)}) begin
          n_fail++; $display("FAIL full_wr_%0d got=%h exp=%h", i, {s_we, s_addr, s_wdata, s_count}, {1'b1, 2'(acc - 1), enc(7, i, i + 1, 0, i, 0), 3'(acc)}); end
      end else begin
        n_chk++; if ({s_we, s_count} !== {1'b0, 3'(acc)}) begin
          n_fail++; $display("FAIL full_stall_%0d got=%h exp=%h", i, {s_we, s_count}, {1'b0, 3'(acc)}); end
      end
    end
    in_valid = 0; flush = 1;
    step;
    flush = 0;
    n_chk++; if ({s_we, s_addr, s_wdata, s_count, s_done} !== {1'b1, 2'd3, TERM, 3'd4, 1'b0}) begin
      n_fail++; $display("FAIL full_term got=%h exp=%h", {s_we, s_addr, s_wdata, s_count, s_done}, {1'b1, 2'd3, TERM, 3'd4, 1'b0}); end
    step;
    n_chk++; if ({s_done, s_we, s_ready} !== 3'b100) begin n_fail++; $display("FAIL full_done got=%b exp=100", {s_done, s_we, s_ready}); end
  endtask

  task automatic test_flush_xfer;
    do_start;
    drive(7, 1, 2, 0, 3, 0);
    flush = 1;
    step;
    in_valid = 0; flush = 0;
    n_chk++; if ({im_we, im_addr, im_wdata, in_ready, done} !== {1'b1, 4'd0, 32'h10220003, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL fx_instr got=%h exp=%h", {im_we, im_addr, im_wdata, in_ready, done}, {1'b1, 4'd0, 32'h10220003, 1'b0, 1'b0}); end
    step;
    n_chk++; if ({im_we, im_addr, im_wdata, count, done} !== {1'b1, 4'd1, TERM, 5'd2, 1'b0}) begin
      n_fail++; $display("FAIL fx_term got=%h exp=%h", {im_we, im_addr, im_wdata, count, done}, {1'b1, 4'd1, TERM, 5'd2, 1'b0}); end
    step;
    n_chk++; if ({im_we, done} !== 2'b01) begin n_fail++; $display("FAIL fx_done got=%b exp=01", {im_we, done}); end
  endtask

  task automatic test_random;
    logic [31:0] exp[$];
    logic [31:0] want;
    int nerr, k, rs, rt, rd, imm, tgt;
    for (int s = 0; s < 3; s++) begin
      exp.delete();
      nerr = 0;
      do_start;
      for (int i = 0; i < 12; i++) begin
        if ($urandom_range(0, 3) != 0) begin
          k = $urandom_range(0, 12);
          if (k > 9) k = $urandom_range(10, 15);
          rs = $urandom_range(0, 31); rt = $urandom_range(0, 31); rd = $urandom_range(0, 31);
          imm = $urandom_range(0, 65535); tgt = $urandom_range(0, 67108863);
          drive(k, rs, rt, rd, imm, tgt);
          if (k <= 9) exp.push_back(enc(k, rs, rt, rd, imm, tgt)); else nerr++;
        end else in_valid = 0;
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rnd_ready_%0d_%0d got=%b exp=1", s, i, in_ready); end
        step;
      end
      end_session;
      n_chk++; if (wq.size() !== exp.size() + 1) begin
        n_fail++; $display("FAIL rnd_nwr_%0d got=%0d exp=%0d", s, wq.size(), exp.size() + 1); end
      foreach (wq[j]) begin
        want = (j < exp.size()) ? exp[j] : TERM;
        n_chk++; if (wq[j].addr !== j || wq[j].data !== want) begin
          n_fail++; $display("FAIL rnd_wr_%0d_%0d got=%0d:%h exp=%0d:%h", s, j, wq[j].addr, wq[j].data, j, want); end
      end
      n_chk++; if ({count, done} !== {5'(exp.size() + 1), 1'b1}) begin
        n_fail++; $display("FAIL rnd_count_%0d got=%h exp=%h", s, {count, done}, {5'(exp.size() + 1), 1'b1}); end
      n_chk++; if (errs !== nerr) begin n_fail++; $display("FAIL rnd_err_%0d got=%0d exp=%0d", s, errs, nerr); end
    end
  endtask

  task automatic test_reset_mid;
    do_start;
    for (int i = 0; i < 3; i++) begin
      drive(1, i, i, i, 0, 0);
      step;
    end
    reset = 0;
    step;
    n_chk++; if ({im_we, count, in_ready, done} !== '0) begin
      n_fail++; $display("FAIL rmid_clear got=%h exp=0", {im_we, count, in_ready, done}); end
    reset = 1; in_valid = 0;
    wq.delete();
    step; step;
    n_chk++; if (wq.size() !== 0 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL rmid_quiet got=%0d/%b exp=0/0", wq.size(), in_ready); end
    do_start;
    drive(4, 1, 2, 0, 'h55, 0);
    step;
    in_valid = 0;
    n_chk++; if ({im_we, im_addr, im_wdata, count} !== {1'b1, 4'd0, enc(4, 1, 2, 0, 'h55, 0), 5'd1}) begin
      n_fail++; $display("FAIL rmid_reload got=%h exp=%h", {im_we, im_addr, im_wdata, count}, {1'b1, 4'd0, enc(4, 1, 2, 0, 'h55, 0), 5'd1}); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_back_to_back;
    test_illegal;
    test_full;
    test_flush_xfer;
    test_random;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
